// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants: instruction-format tags, field widths and common opcodes.
package mips_pkg;

    localparam int OP_W    = 6;
    localparam int REG_W   = 5;
    localparam int SHAMT_W = 5;
    localparam int FUNC_W  = 6;
    localparam int IMM_W   = 16;
    localparam int JADDR_W = 26;

    typedef enum logic [1:0] {
        FMT_R   = 2'b00,
        FMT_I   = 2'b01,
        FMT_J   = 2'b10,
        FMT_BAD = 2'b11
    } fmt_e;

    localparam logic [OP_W-1:0] OPC_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OPC_J     = 6'h02;
    localparam logic [OP_W-1:0] OPC_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OPC_LW    = 6'h23;
    localparam logic [OP_W-1:0] OPC_SW    = 6'h2B;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DONE
    } asm_state_e;

endpackage

// File: rtl/inst_assembler_if.sv
// Decoded-field stream from the program loader into the assembler (valid/ready).
interface inst_assembler_if;

    logic                        in_valid;
    logic                        in_ready;
    logic [1:0]                  fmt;
    logic [mips_pkg::OP_W-1:0]    OP;
    logic [mips_pkg::REG_W-1:0]   RS;
    logic [mips_pkg::REG_W-1:0]   RT;
    logic [mips_pkg::REG_W-1:0]   RD;
    logic [mips_pkg::SHAMT_W-1:0] SHMAT;
    logic [mips_pkg::FUNC_W-1:0]  FUNC;
    logic [mips_pkg::IMM_W-1:0]   IMME;
    logic [mips_pkg::JADDR_W-1:0] ADDR;
    logic                        last;

    modport master (
        output in_valid, fmt, OP, RS, RT, RD, SHMAT, FUNC, IMME, ADDR, last,
        input  in_ready
    );

    modport slave (
        input  in_valid, fmt, OP, RS, RT, RD, SHMAT, FUNC, IMME, ADDR, last,
        output in_ready
    );

endinterface

// File: rtl/inst_pack.sv
// Combinational packer: format tag plus decoded fields back into a 32-bit MIPS word.
module inst_pack
    import mips_pkg::*;
(
    input  logic [1:0]         i_fmt,
    input  logic [OP_W-1:0]    i_op,
    input  logic [REG_W-1:0]   i_rs,
    input  logic [REG_W-1:0]   i_rt,
    input  logic [REG_W-1:0]   i_rd,
    input  logic [SHAMT_W-1:0] i_shamt,
    input  logic [FUNC_W-1:0]  i_func,
    input  logic [IMM_W-1:0]   i_imm,
    input  logic [JADDR_W-1:0] i_jaddr,
    output logic [31:0]        o_word
);

    always_comb begin
        o_word = '0;
        case (fmt_e'(i_fmt))
            FMT_R:   o_word = {i_op, i_rs, i_rt, i_rd, i_shamt, i_func};
            FMT_I:   o_word = {i_op, i_rs, i_rt, i_imm};
            FMT_J:   o_word = {i_op, i_jaddr};
            default: o_word = '0;
        endcase
    end

endmodule

// File: rtl/inst_assembler.sv
// Load-session FSM that packs streamed field groups and writes them sequentially
// into instruction memory starting at BASE_ADDR.
module inst_assembler
    import mips_pkg::*;
#(
    parameter int DEPTH     = 256,
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              myreset,
    input  logic              start,
    inst_assembler_if.slave   fin,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   count,
    output logic              err_fmt
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_C  = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] BASE_C  = (ADDR_W+1)'(BASE_ADDR);

    asm_state_e        r_state, w_state_nxt;
    logic              r_imem_we;
    logic [ADDR_W-1:0] r_imem_addr;
    logic [31:0]       r_imem_wdata;
    logic [ADDR_W:0]   r_count;
    logic              r_err_fmt;

    logic              w_xfer, w_legal, w_fill;
    logic [31:0]       w_word;
    logic [ADDR_W:0]   w_addr_sum;

    inst_pack u_pack (
        .i_fmt   (fin.fmt),
        .i_op    (fin.OP),
        .i_rs    (fin.RS),
        .i_rt    (fin.RT),
        .i_rd    (fin.RD),
        .i_shamt (fin.SHMAT),
        .i_func  (fin.FUNC),
        .i_imm   (fin.IMME),
        .i_jaddr (fin.ADDR),
        .o_word  (w_word)
    );

    assign w_xfer     = fin.in_valid && fin.in_ready;
    assign w_legal    = (fin.fmt != FMT_BAD);
    // Leave LOAD on the transfer that fills memory so done lines up with the final write.
    assign w_fill     = w_xfer && w_legal && (r_count == LAST_C);
    assign w_addr_sum = BASE_C + r_count;

    always_ff @(posedge clk or negedge myreset) begin
        if (!myreset) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_nxt = ST_LOAD;
            ST_LOAD: if ((w_xfer && fin.last) || w_fill || (r_count >= DEPTH_C))
                         w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        fin.in_ready = (r_state == ST_LOAD) && (r_count < DEPTH_C);
        busy         = (r_state != ST_IDLE);
        done         = (r_state == ST_DONE);
    end

    always_ff @(posedge clk or negedge myreset) begin
        if (!myreset) begin
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= '0;
            r_count      <= '0;
            r_err_fmt    <= 1'b0;
        end else begin
            r_imem_we <= w_xfer && w_legal;
            if ((r_state == ST_IDLE) && start) begin
                r_count   <= '0;
                r_err_fmt <= 1'b0;
            end else if (w_xfer) begin
                if (w_legal) begin
                    r_imem_addr  <= w_addr_sum[ADDR_W-1:0];
                    r_imem_wdata <= w_word;
                    r_count      <= r_count + ONE_C;
                end else begin
                    r_err_fmt <= 1'b1;
                end
            end
        end
    end

    assign imem_we    = r_imem_we;
    assign imem_addr  = r_imem_addr;
    assign imem_wdata = r_imem_wdata;
    assign count      = r_count;
    assign err_fmt    = r_err_fmt;

endmodule
